uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving input buffer entries (power of 2, legal 2..16).
REQ-003 The block SHALL have parameter PRESCALE_W, default 8, giving the width of the PRESCALE input.
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port RST, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port P_DATA, input, DATA_WIDTH, the write data word.
REQ-007 The block SHALL have port DATA_VALID, input, 1, the write request.
REQ-008 The block SHALL have port DATA_READY, output, 1, high when the FIFO is not full.
REQ-009 The block SHALL have port PAR_EN, input, 1, parity bit enable.
REQ-010 The block SHALL have port PAR_TYP, input, 1, parity type: 0 = even, 1 = odd.
REQ-011 The block SHALL have port STOP2, input, 1, stop bits: 0 = one stop bit, 1 = two stop bits.
REQ-012 The block SHALL have port PRESCALE, input, PRESCALE_W, giving CLK cycles per bit minus 1.
REQ-013 The block SHALL have port TX_OUT, output, 1, the serial line, idle high.
REQ-014 The block SHALL have port Busy, output, 1, high while a frame is on the line.
REQ-015 The block SHALL have port FIFO_COUNT, output, clog2(FIFO_DEPTH)+1, the number of stored words.

Function
REQ-016 A word SHALL be written on a rising edge where DATA_VALID=1 and DATA_READY=1; DATA_VALID with DATA_READY=0 is ignored and nothing is stored.
REQ-017 DATA_READY SHALL equal (FIFO_COUNT < FIFO_DEPTH), decoded from registered state. A write while full is dropped even if a pop occurs on the same edge.
REQ-018 A simultaneous write and pop SHALL leave FIFO_COUNT unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP1 and STOP_2.
REQ-020 In IDLE with FIFO_COUNT!=0, the next edge SHALL pop the head word, latch PAR_EN/PAR_TYP/STOP2/PRESCALE for the whole frame, and enter START.
REQ-021 Every state except IDLE SHALL last exactly PRESCALE+1 cycles, counted by an internal bit-timer that is reloaded on each state entry.
REQ-022 Transitions SHALL be: START->DATA; DATA, after DATA_WIDTH bits sent LSB first, ->PARITY if PAR_EN else ->STOP1; PARITY->STOP1; STOP1->STOP_2 if STOP2 else ->end; STOP_2->end.
REQ-023 At end of frame, the FSM SHALL go directly to START (next word popped on the same edge) if FIFO_COUNT!=0, else to IDLE. No idle bit is inserted between back-to-back frames.
REQ-024 TX_OUT SHALL be registered: 1 in IDLE/STOP1/STOP_2, 0 in START, data bit in DATA, and in PARITY the XOR of the data bits (even) or its inverse (odd).
REQ-025 Busy SHALL be registered and high exactly while the FSM is not in IDLE.
REQ-026 Frame length SHALL be (1+DATA_WIDTH+PAR_EN+1+STOP2)*(PRESCALE+1) cycles.
REQ-027 Latency: a write at edge N into an empty FIFO while IDLE SHALL drive TX_OUT=0 and Busy=1 after edge N+1.
REQ-028 Configuration input changes mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-029 RST=0 SHALL immediately force: FSM=IDLE, TX_OUT=1, Busy=0, FIFO_COUNT=0, pointers=0, bit-timer=0, DATA_READY=1.
REQ-030 Reset mid-frame SHALL abort the frame and discard all buffered words. After RST rises, no word shall be transmitted until a new write.

Verification
REQ-031 PRESCALE=0, PAR_EN=0, STOP2=0, write 8'hA2 -> TX_OUT after edges N+1..N+10 = 0,0,1,0,0,0,1,0,1,1; Busy high 10 cycles.
REQ-032 PRESCALE=0, PAR_EN=1, PAR_TYP=0, write 8'h66 -> parity bit 0, frame 11 cycles; with PAR_TYP=1 -> parity bit 1.
REQ-033 PRESCALE=3, STOP2=1, PAR_EN=1, write 8'hEB -> each bit held 4 cycles, frame 48 cycles, two stop bits high.
REQ-034 Write 5 words back-to-back with FIFO_DEPTH=4 while IDLE -> 5th accepted only if the first pop has occurred, else DATA_READY=0 and it is dropped; frames are contiguous with no idle gap; count returns to 0.
REQ-035 Assert RST=0 mid-DATA with 3 words queued -> TX_OUT=1, Busy=0, FIFO_COUNT=0 immediately; line stays idle after release.
REQ-036 Change PAR_EN and PRESCALE during a frame -> current frame unchanged; next frame uses new values.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO. Frames are start, LSB-first data,
// optional parity and one or two stop bits, with per-frame latched configuration.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  output logic                          TX_OUT,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP_2} state_t;

  state_t                  state_reg, state_next;
  logic [PRESCALE_W-1:0]   timer_reg, timer_next;
  logic [BIT_W-1:0]        bit_idx_reg, bit_idx_next;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    par_en_reg, par_typ_reg, stop2_reg;
  logic [PRESCALE_W-1:0]   prescale_reg;
  logic                    tx_reg, tx_next;
  logic                    busy_reg, busy_next;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;
  logic                    wr_en, pop, frame_end;

  // Ready comes only from the registered count, so a write while full is lost
  // even if the transmitter pops on the same edge.
  assign DATA_READY = (count_reg < DEPTH_C);
  assign wr_en      = DATA_VALID && DATA_READY;
  assign FIFO_COUNT = count_reg;
  assign TX_OUT     = tx_reg;
  assign Busy       = busy_reg;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= P_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  // State register plus the frame datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      bit_idx_reg  <= '0;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      prescale_reg <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      if (pop) begin
        data_reg     <= mem[rd_ptr_reg];
        par_en_reg   <= PAR_EN;
        par_typ_reg  <= PAR_TYP;
        stop2_reg    <= STOP2;
        prescale_reg <= PRESCALE;
      end
    end
  end

  // Next state: each non-idle state holds until the bit-timer reaches zero
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_idx_next = bit_idx_reg;
    pop          = 1'b0;
    frame_end    = 1'b0;
    if (state_reg == IDLE) begin
      pop = (count_reg != '0);
    end else if (timer_reg != '0) begin
      timer_next = timer_reg - PRESCALE_W'(1);
    end else begin
      timer_next = prescale_reg;
      case (state_reg)
        START: begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
        DATA: begin
          if (bit_idx_reg == LAST_BIT) begin
            state_next = par_en_reg ? PARITY : STOP1;
          end else begin
            bit_idx_next = bit_idx_reg + BIT_W'(1);
          end
        end
        PARITY: state_next = STOP1;
        STOP1: begin
          if (stop2_reg) state_next = STOP_2;
          else           frame_end  = 1'b1;
        end
        STOP_2:  frame_end  = 1'b1;
        default: state_next = IDLE;
      endcase
    end
    if (frame_end) begin
      if (count_reg != '0) pop = 1'b1;
      else                 state_next = IDLE;
    end
    // A new frame times its start bit from the live PRESCALE being latched now
    if (pop) begin
      state_next = START;
      timer_next = PRESCALE;
    end
  end

  // Outputs are registered, so decode them from the state being entered
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_reg[bit_idx_next];
      PARITY:  tx_next = (^data_reg) ^ par_typ_reg;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: each accepted word queues its expected
// per-cycle line levels, which a monitor pops and compares while Busy is high.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       PAR_EN, PAR_TYP, STOP2;
  logic [7:0] PRESCALE;
  logic       TX_OUT, Busy;
  logic [2:0] FIFO_COUNT;

  int vectors     = 0;
  int miscompares = 0;
  int busy_cycles = 0;
  int busy_rises  = 0;
  logic prev_busy = 1'b0;
  logic exp_q [$];

  logic       m_par_en, m_par_typ, m_stop2;
  int         m_pre;
  int         b0, r0;

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_W(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .Busy(Busy), .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task set_cfg(input logic pe, input logic pt, input logic s2, input int pre);
    m_par_en = pe; m_par_typ = pt; m_stop2 = s2; m_pre = pre;
    PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = 8'(pre);
  endtask

  task push_level(input logic lvl);
    for (int k = 0; k <= m_pre; k++) exp_q.push_back(lvl);
  endtask

  task push_frame(input logic [7:0] d);
    push_level(1'b0);
    for (int i = 0; i < 8; i++) push_level(d[i]);
    if (m_par_en) push_level((^d) ^ m_par_typ);
    push_level(1'b1);
    if (m_stop2) push_level(1'b1);
  endtask

  task do_write(input logic [7:0] d, input logic exp_acc);
    @(negedge CLK);
    P_DATA = d;
    DATA_VALID = 1'b1;
    check("data_ready", DATA_READY, exp_acc);
    if (exp_acc) push_frame(d);
    $display("write %02h expect_accept=%0d count=%0d", d, exp_acc, FIFO_COUNT);
    @(posedge CLK);
    #1 DATA_VALID = 1'b0;
  endtask

  task monitor();
    forever begin
      @(negedge CLK);
      if (Busy) begin
        busy_cycles++;
        if (!prev_busy) busy_rises++;
        if (exp_q.size() == 0) check("tx_extra", 32'd1, 32'd0);
        else check("tx_bit", TX_OUT, exp_q.pop_front());
      end else begin
        check("idle_line", TX_OUT, 1'b1);
      end
      prev_busy = Busy;
    end
  endtask

  task wait_idle(input int maxc);
    int n;
    n = 0;
    while ((Busy || exp_q.size() != 0) && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    if (n >= maxc) check("timeout_idle", 32'd0, 32'd1);
  endtask

  initial begin
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0;
    set_cfg(1'b0, 1'b0, 1'b0, 0);
    fork
      monitor();
    join_none
    repeat (3) @(negedge CLK);
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_count", FIFO_COUNT, 3'd0);
    check("rst_ready", DATA_READY, 1'b1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Basic frame and first-bit latency
    set_cfg(1'b0, 1'b0, 1'b0, 0);
    b0 = busy_cycles; r0 = busy_rises;
    do_write(8'hA2, 1'b1);
    check("lat_count", FIFO_COUNT, 3'd1);
    check("lat_busy_n", Busy, 1'b0);
    check("lat_tx_n", TX_OUT, 1'b1);
    @(posedge CLK); #1;
    check("lat_busy_n1", Busy, 1'b1);
    check("lat_tx_n1", TX_OUT, 1'b0);
    wait_idle(100);
    check("a2_len", busy_cycles - b0, 10);
    check("a2_rises", busy_rises - r0, 1);

    // Even then odd parity
    for (int t = 0; t < 2; t++) begin
      set_cfg(1'b1, t[0], 1'b0, 0);
      b0 = busy_cycles;
      do_write(8'h66, 1'b1);
      wait_idle(100);
      check("par_len", busy_cycles - b0, 11);
    end

    // Slow bit rate with parity and two stop bits
    set_cfg(1'b1, 1'b0, 1'b1, 3);
    b0 = busy_cycles;
    do_write(8'hEB, 1'b1);
    wait_idle(200);
    check("eb_len", busy_cycles - b0, 48);

    // Burst of five fills the FIFO once the first word is popped; sixth dropped
    set_cfg(1'b0, 1'b0, 1'b0, 0);
    b0 = busy_cycles; r0 = busy_rises;
    do_write(8'h11, 1'b1);
    do_write(8'h22, 1'b1);
    do_write(8'h33, 1'b1);
    do_write(8'h44, 1'b1);
    do_write(8'h55, 1'b1);
    check("full_count", FIFO_COUNT, 3'd4);
    check("full_ready", DATA_READY, 1'b0);
    do_write(8'h99, 1'b0);
    check("drop_count", FIFO_COUNT, 3'd4);
    wait_idle(300);
    check("burst_len", busy_cycles - b0, 50);
    check("burst_rises", busy_rises - r0, 1);
    check("burst_count", FIFO_COUNT, 3'd0);

    // Reset in the middle of a data bit with three words queued
    set_cfg(1'b0, 1'b0, 1'b0, 3);
    do_write(8'hF0, 1'b1);
    do_write(8'h0F, 1'b1);
    do_write(8'hAA, 1'b1);
    do_write(8'h55, 1'b1);
    check("pre_rst_count", FIFO_COUNT, 3'd3);
    repeat (6) @(negedge CLK);
    check("pre_rst_busy", Busy, 1'b1);
    #1 RST = 1'b0;
    #1;
    check("arst_tx", TX_OUT, 1'b1);
    check("arst_busy", Busy, 1'b0);
    check("arst_count", FIFO_COUNT, 3'd0);
    check("arst_ready", DATA_READY, 1'b1);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    r0 = busy_rises;
    repeat (40) @(negedge CLK);
    check("post_rst_rises", busy_rises - r0, 0);
    check("post_rst_count", FIFO_COUNT, 3'd0);
    set_cfg(1'b0, 1'b0, 1'b0, 0);
    b0 = busy_cycles;
    do_write(8'h5A, 1'b1);
    wait_idle(100);
    check("recover_len", busy_cycles - b0, 10);

    // Config changed mid-frame applies only to the next frame
    set_cfg(1'b0, 1'b0, 1'b0, 1);
    b0 = busy_cycles; r0 = busy_rises;
    do_write(8'hC3, 1'b1);
    for (int n = 0; n < 10 && !Busy; n++) @(negedge CLK);
    check("cfg_busy_seen", Busy, 1'b1);
    set_cfg(1'b1, 1'b1, 1'b1, 0);
    do_write(8'h3C, 1'b1);
    wait_idle(200);
    check("cfg_len", busy_cycles - b0, 32);
    check("cfg_rises", busy_rises - r0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
